// File: rtl/timing_phase_sequencer.sv
// Machine-cycle phase sequencer: free-run, single-step, clean halt and hold wait states.
// Optional feature: define SEQ_SINGLE_STEP_EN to enable the step input and STEP state.
module timing_phase_sequencer #(
  parameter int unsigned LAST_PHASE = 7
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_run,
  input  logic       i_step,
  input  logic       i_halt_req,
  input  logic       i_hold,
  output logic [2:0] o_phase,
  output logic       o_phase_valid,
  output logic       o_running,
  output logic       o_cycle_done
);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRun     = 2'd1,
    StHalting = 2'd2
`ifdef SEQ_SINGLE_STEP_EN
    ,
    StStep    = 2'd3
`endif
  } state_e;

  localparam logic [2:0] LastPhase = 3'(LAST_PHASE);

  state_e     r_state;
  state_e     w_state_d;
  logic [2:0] r_phase;
  logic [2:0] w_phase_d;
  logic       r_phase_valid;
  logic       r_running;
  logic       r_cycle_done;
  logic       w_cycle_done_d;
  logic       w_at_last;
  logic       w_stop;
  logic       w_start_step;

`ifdef SEQ_SINGLE_STEP_EN
  assign w_start_step = i_step && !i_halt_req;
`else
  logic w_unused_step;
  assign w_unused_step = i_step;
  assign w_start_step  = 1'b0;
`endif

  assign w_at_last = (r_phase == LastPhase);
  assign w_stop    = !i_run || i_halt_req;

  always_comb begin
    w_state_d      = r_state;
    w_phase_d      = r_phase;
    w_cycle_done_d = 1'b0;
    case (r_state)
      StIdle: begin
        w_phase_d = 3'd0;
        if (i_run && !i_halt_req) begin
          w_state_d = StRun;
        end else if (w_start_step) begin
`ifdef SEQ_SINGLE_STEP_EN
          w_state_d = StStep;
`endif
        end
      end
`ifdef SEQ_SINGLE_STEP_EN
      StRun, StHalting, StStep: begin
`else
      StRun, StHalting: begin
`endif
        // Hold freezes both phase and state; no exit is taken mid-wait.
        if (!i_hold) begin
          w_phase_d      = w_at_last ? 3'd0 : r_phase + 3'd1;
          w_cycle_done_d = w_at_last;
          if (r_state == StRun) begin
            if (w_stop) w_state_d = w_at_last ? StIdle : StHalting;
          end else if (w_at_last) begin
            w_state_d = StIdle;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_phase_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= StIdle;
      r_phase       <= 3'd0;
      r_phase_valid <= 1'b0;
      r_running     <= 1'b0;
      r_cycle_done  <= 1'b0;
    end else begin
      r_state       <= w_state_d;
      r_phase       <= w_phase_d;
      r_phase_valid <= (w_state_d != StIdle);
      r_running     <= (w_state_d == StRun);
      r_cycle_done  <= w_cycle_done_d;
    end
  end

  assign o_phase       = r_phase;
  assign o_phase_valid = r_phase_valid;
  assign o_running     = r_running;
  assign o_cycle_done  = r_cycle_done;

endmodule
